// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the floating-point normalize/pack back end.
//   fp32_t  : IEEE-754 single-precision field layout {sign, exp, frac}
//   state_t : normalizer FSM states
//   EXP_MAX, EXP_MIN_NORM, INF_FRAC : encoding constants
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam logic [7:0]  EXP_MAX      = 8'hFF;
    localparam logic [7:0]  EXP_MIN_NORM = 8'h01;
    localparam logic [22:0] INF_FRAC     = 23'h0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_SHIFT_L = 2'd2,
        ST_PACK    = 2'd3
    } state_t;

endpackage

// File: rtl/fp_pack.sv
// ----------------------------------------------------------------------------
// fp_pack
// Combinational selection of the final single-precision encoding.
// Ports:
//   sign      in   result sign
//   exp       in   normalized biased exponent
//   frac      in   normalized fraction (hidden bit dropped)
//   overflow  in   select signed infinity
//   underflow in   select +0 (flush, no denormals)
//   zero      in   select +0
//   result    out  packed fp32 word
// Zero and underflow take precedence and always produce a positive zero.
// ----------------------------------------------------------------------------
module fp_pack
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [22:0] frac,
    input  logic        overflow,
    input  logic        underflow,
    input  logic        zero,
    output fp32_t       result
);

    always_comb begin
        result = '0;
        if (zero || underflow) begin
            result = '0;
        end else if (overflow) begin
            result = '{sign: sign, exp: EXP_MAX, frac: INF_FRAC};
        end else begin
            result = '{sign: sign, exp: exp, frac: frac};
        end
    end

endmodule

// File: rtl/fp_normalize_pack.sv
// ----------------------------------------------------------------------------
// fp_normalize_pack
// Back end of the FP add/sub datapath: iterative normalization of the adder
// magnitude (one right shift on carry-out, else one left shift per cycle
// until the hidden bit is set) and IEEE-754 single-precision packing.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   clock enable, low freezes all state
//   start      in   operand strobe, accepted only in IDLE
//   mant_in    in   adder magnitude (24b incl. hidden bit position)
//   carry_in   in   adder carry-out
//   sign_in    in   result sign
//   exp_in     in   biased common exponent
//   busy       out  operation in flight
//   done       out  one-cycle completion pulse
//   result     out  packed {sign, exp, frac}, held until next done
//   overflow   out  result is signed infinity
//   underflow  out  result flushed to +0
//   zero       out  result is exact +0
//
// Build option: FPN_ROUND_EN enables round-to-nearest-even of the bit lost
// by the carry right shift; without it the bit is truncated.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for start; outputs hold last result
// CHECK    | special-case screen; on carry performs the right shift (and
//          | rounding) then re-screens next cycle, which catches exp==255
// SHIFT_L  | one left shift per cycle until hidden bit set or exp reaches 1
// PACK     | register packed result and flags, pulse done
// ----------------------------------------------------------------------------
module fp_normalize_pack #(
    parameter int MANT_W  = 24,
    parameter int EXP_W   = 8,
    parameter int EXP_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              carry_in,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow,
    output logic              zero
);
    import fp_pkg::*;

    localparam logic [EXP_W-1:0]  EXP_ALL1  = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(EXP_MIN_NORM);
    localparam logic [MANT_W-1:0] MANT_HIDN = {1'b1, {(MANT_W-1){1'b0}}};

    state_t            state, state_n;
    logic [MANT_W-1:0] mant_r, mant_n;
    logic [EXP_W-1:0]  exp_r, exp_n;
    logic              carry_r, carry_n;
    logic              sign_r, sign_n;
    logic              ovf_r, ovf_n;
    logic              unf_r, unf_n;
    logic              zro_r, zro_n;
    logic              busy_n, done_n;
    logic [31:0]       result_n;
    logic              overflow_n, underflow_n, zero_n;
    logic [MANT_W-1:0] shr_mant;
    fp32_t             packed_res;

`ifdef FPN_ROUND_EN
    localparam logic [EXP_W:0] EXP_SAT = {1'b0, EXP_ALL1};
    logic [EXP_W:0] exp_inc2;
    assign exp_inc2 = {1'b0, exp_r} + (EXP_W+1)'(2);
`endif

    assign shr_mant = {carry_r, mant_r[MANT_W-1:1]};

    fp_pack u_pack (
        .sign      (sign_r),
        .exp       (exp_r),
        .frac      (mant_r[MANT_W-2:0]),
        .overflow  (ovf_r),
        .underflow (unf_r),
        .zero      (zro_r),
        .result    (packed_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        mant_n      = mant_r;
        exp_n       = exp_r;
        carry_n     = carry_r;
        sign_n      = sign_r;
        ovf_n       = ovf_r;
        unf_n       = unf_r;
        zro_n       = zro_r;
        busy_n      = busy;
        done_n      = 1'b0;
        result_n    = result;
        overflow_n  = overflow;
        underflow_n = underflow;
        zero_n      = zero;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    mant_n  = mant_in;
                    exp_n   = exp_in;
                    carry_n = carry_in;
                    sign_n  = sign_in;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                    zro_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (exp_r == EXP_ALL1) begin
                    ovf_n   = 1'b1;
                    state_n = ST_PACK;
                end else if (!carry_r && (mant_r == '0)) begin
                    zro_n   = 1'b1;
                    state_n = ST_PACK;
                end else if (exp_r == '0) begin
                    unf_n   = 1'b1;
                    state_n = ST_PACK;
                end else if (carry_r) begin
                    // exp_r <= 254 here, so +1 cannot wrap. Staying in CHECK
                    // lets the next pass flag a 255 exponent as overflow.
                    carry_n = 1'b0;
                    mant_n  = shr_mant;
                    exp_n   = exp_r + EXP_W'(1);
`ifdef FPN_ROUND_EN
                    if (mant_r[0] && shr_mant[0]) begin
                        if (&shr_mant) begin
                            mant_n = MANT_HIDN;
                            exp_n  = (exp_inc2 > EXP_SAT) ? EXP_ALL1 : exp_inc2[EXP_W-1:0];
                        end else begin
                            mant_n = shr_mant + MANT_W'(1);
                        end
                    end
`endif
                end else if (mant_r[MANT_W-1]) begin
                    state_n = ST_PACK;
                end else begin
                    state_n = ST_SHIFT_L;
                end
            end

            ST_SHIFT_L: begin
                if (exp_r == EXP_ONE) begin
                    unf_n   = 1'b1;
                    state_n = ST_PACK;
                end else begin
                    mant_n = mant_r << 1;
                    exp_n  = exp_r - EXP_W'(1);
                    if (mant_r[MANT_W-2]) begin
                        state_n = ST_PACK;
                    end
                end
            end

            ST_PACK: begin
                result_n    = packed_res;
                overflow_n  = ovf_r;
                underflow_n = unf_r;
                zero_n      = zro_r;
                done_n      = 1'b1;
                busy_n      = 1'b0;
                state_n     = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_r    <= '0;
            exp_r     <= '0;
            carry_r   <= 1'b0;
            sign_r    <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            zro_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            mant_r    <= mant_n;
            exp_r     <= exp_n;
            carry_r   <= carry_n;
            sign_r    <= sign_n;
            ovf_r     <= ovf_n;
            unf_r     <= unf_n;
            zro_r     <= zro_n;
            busy      <= busy_n;
            done      <= done_n;
            result    <= result_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
            zero      <= zero_n;
        end
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// ----------------------------------------------------------------------------
// tb_fp_normalize_pack
// Table-driven bench for fp_normalize_pack with a scoreboard queue, plus
// hand-written sequences for start-while-busy, clock-enable stalls and
// reset in the middle of a shift sequence.
// ----------------------------------------------------------------------------
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [23:0] mant_in;
    logic        carry_in;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        zero;

    fp_normalize_pack dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .mant_in   (mant_in),
        .carry_in  (carry_in),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] mant;
        logic        c;
        logic        s;
        logic [7:0]  e;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zro;
        int          lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];
    vec_t sb_q[$];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [23:0] mant, input logic c, input logic s,
                                input logic [7:0] e, input logic [31:0] res,
                                input logic ovf, input logic unf, input logic zro,
                                input int lat);
        vec_t v;
        v.mant = mant; v.c = c; v.s = s; v.e = e; v.res = res;
        v.ovf = ovf; v.unf = unf; v.zro = zro; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drives one operation, waits (bounded) for done, compares with the
    // scoreboard head. Optional en stall window and a start pulse while busy.
    task automatic do_op(input vec_t v, input int stall_at, input int stall_len,
                         input bit poke, input string tag);
        int   edges;
        bit   got;
        vec_t e;
        logic [31:0] held;
        @(negedge clk);
        mant_in = v.mant; carry_in = v.c; sign_in = v.s; exp_in = v.e;
        start = 1'b1; en = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        got = 1'b0;
        chk({tag, " busy after start"}, 32'(busy), 32'd1);
        while (!got && edges < 100) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                en = !(stall_len > 0 && edges >= stall_at && edges < stall_at + stall_len);
                if (poke && edges == 3) begin
                    start = 1'b1; mant_in = 24'h5A5A5A; carry_in = 1'b1;
                    exp_in = 8'h10; sign_in = ~v.s;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                edges++;
            end
        end
        en = 1'b1;
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done after %0d edges", tag, edges);
            sb_q.delete();
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: done with empty queue", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " latency"}, 32'(edges), 32'(e.lat + stall_len));
            chk({tag, " result"}, result, e.res);
            chk({tag, " flags"}, {29'd0, overflow, underflow, zero}, {29'd0, e.ovf, e.unf, e.zro});
            chk({tag, " busy at done"}, 32'(busy), 32'd0);
            held = result;
            @(negedge clk);
            chk({tag, " done pulse width"}, 32'(done), 32'd0);
            chk({tag, " result held"}, result, held);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;

        vecs[0]  = mk(24'hC00000, 1'b0, 1'b0, 8'h80, 32'h40400000, 0, 0, 0, 2);
        vecs[1]  = mk(24'h000000, 1'b1, 1'b0, 8'h7F, 32'h40000000, 0, 0, 0, 3);
        vecs[2]  = mk(24'h100000, 1'b0, 1'b1, 8'h80, 32'hBE800000, 0, 0, 0, 5);
        vecs[3]  = mk(24'h000000, 1'b0, 1'b1, 8'h55, 32'h00000000, 0, 0, 1, 2);
        vecs[4]  = mk(24'h000000, 1'b1, 1'b0, 8'hFE, 32'h7F800000, 1, 0, 0, 3);
`ifdef FPN_ROUND_EN
        vecs[5]  = mk(24'h000003, 1'b1, 1'b0, 8'h7F, 32'h40000002, 0, 0, 0, 3);
`else
        vecs[5]  = mk(24'h000003, 1'b1, 1'b0, 8'h7F, 32'h40000001, 0, 0, 0, 3);
`endif
        vecs[6]  = mk(24'h800000, 1'b0, 1'b1, 8'hFF, 32'hFF800000, 1, 0, 0, 2);
        vecs[7]  = mk(24'h800000, 1'b0, 1'b0, 8'h00, 32'h00000000, 0, 1, 0, 2);
        vecs[8]  = mk(24'h000001, 1'b0, 1'b0, 8'h03, 32'h00000000, 0, 1, 0, 5);
        vecs[9]  = mk(24'h000001, 1'b0, 1'b0, 8'h80, 32'h34800000, 0, 0, 0, 25);
        vecs[10] = mk(24'hFFFFFF, 1'b0, 1'b1, 8'h7F, 32'hBFFFFFFF, 0, 0, 0, 2);
`ifdef FPN_ROUND_EN
        vecs[11] = mk(24'hFFFFFF, 1'b1, 1'b0, 8'h7F, 32'h40800000, 0, 0, 0, 3);
        vecs[12] = mk(24'hFFFFFF, 1'b1, 1'b0, 8'hFD, 32'h7F800000, 1, 0, 0, 3);
`else
        vecs[11] = mk(24'hFFFFFF, 1'b1, 1'b0, 8'h7F, 32'h407FFFFF, 0, 0, 0, 3);
        vecs[12] = mk(24'hFFFFFF, 1'b1, 1'b0, 8'hFD, 32'h7F7FFFFF, 0, 0, 0, 3);
`endif
        vecs[13] = mk(24'h000004, 1'b1, 1'b0, 8'h7F, 32'h40000002, 0, 0, 0, 3);
        vecs[14] = mk(24'h000001, 1'b1, 1'b0, 8'h7F, 32'h40000000, 0, 0, 0, 3);

        rst = 1'b1; en = 1'b1; start = 1'b0;
        mant_in = '0; carry_in = 1'b0; sign_in = 1'b0; exp_in = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'h0);
        chk("reset flags", {29'd0, overflow, underflow, zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i], 0, 0, 1'b0, $sformatf("v%0d", i));
        end

        // start pulsed while busy must be ignored
        do_op(vecs[9], 0, 0, 1'b1, "busy_poke");
        // en held low for 3 cycles in the middle of the shift sequence
        do_op(vecs[2], 2, 3, 1'b0, "en_stall");

        // reset during SHIFT_L: immediate clear, no completion afterwards
        @(negedge clk);
        mant_in = vecs[9].mant; carry_in = vecs[9].c; sign_in = vecs[9].s;
        exp_in = vecs[9].e; start = 1'b1;
        sb_q.push_back(vecs[9]);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("midrst no done", 32'(done_seen), 32'd0);
        chk("midrst idle busy", 32'(busy), 32'd0);
        do_op(vecs[0], 0, 0, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
